// File: rtl/tsmc_digital_1_pkg.sv
// Shared widths and helpers for the interleaved-ADC CIC back-end.
// Internal accumulator width covers the worst-case R^N gain growth on the lane sum.
package tsmc_digital_1_pkg;
  localparam int IN_W     = 6;
  localparam int OFF_W    = 3;
  localparam int CIC_N    = 3;
  localparam int DEC_LOG2 = 3;
  localparam int OUT_W    = 21;
  localparam int DIFF_W   = IN_W + 1;
  localparam int LANE_W   = IN_W + 2;
  localparam int SUM_W    = IN_W + 4;
  localparam int ACC_W    = SUM_W + CIC_N * DEC_LOG2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DFE  = 2'd1,
    SRC_TEG  = 2'd2
  } src_e;

  function automatic logic [DIFF_W-1:0] code_diff(input logic [IN_W-1:0] p,
                                                  input logic [IN_W-1:0] n);
    return {1'b0, p} - {1'b0, n};
  endfunction
endpackage

// File: rtl/cic_decim.sv
// CIC decimator: registered source stage, integrator chain, phase counter,
// comb chain evaluated on the decimation tick, and the OUT/OUT_CLK registers.
module cic_decim
  import tsmc_digital_1_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [SUM_W-1:0] i_sum,
  input  logic             i_en_div,
  output logic [OUT_W-1:0] o_out,
  output logic             o_out_clk
);

  logic [SUM_W-1:0]    r_s;
  logic [ACC_W-1:0]    r_int  [CIC_N];
  logic [ACC_W-1:0]    r_prev [CIC_N];
  logic [DEC_LOG2-1:0] r_phase;

  logic [ACC_W-1:0]    w_s_ext;
  logic [ACC_W-1:0]    w_comb [CIC_N];
  logic [DEC_LOG2-1:0] w_phase_nxt;
  logic                w_tick;

  assign w_s_ext     = {{(ACC_W-SUM_W){r_s[SUM_W-1]}}, r_s};
  assign w_tick      = i_en_div && (r_phase == '1);
  assign w_phase_nxt = i_en_div ? r_phase + 1'b1 : '0;

  always_comb begin
    for (int k = 0; k < CIC_N; k++) w_comb[k] = '0;
    w_comb[0] = r_int[CIC_N-1] - r_prev[0];
    for (int k = 1; k < CIC_N; k++) w_comb[k] = w_comb[k-1] - r_prev[k];
  end

  // OUT_CLK follows the next phase so it rises on the same edge OUT updates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s       <= '0;
      r_phase   <= '0;
      o_out_clk <= 1'b0;
      o_out     <= '0;
      for (int k = 0; k < CIC_N; k++) begin
        r_int[k]  <= '0;
        r_prev[k] <= '0;
      end
    end else begin
      r_s      <= i_sum;
      r_int[0] <= r_int[0] + w_s_ext;
      for (int k = 1; k < CIC_N; k++) r_int[k] <= r_int[k] + r_int[k-1];
      r_phase   <= w_phase_nxt;
      o_out_clk <= i_en_div && !w_phase_nxt[DEC_LOG2-1];
      if (w_tick) begin
        r_prev[0] <= r_int[CIC_N-1];
        for (int k = 1; k < CIC_N; k++) r_prev[k] <= w_comb[k-1];
        o_out <= {{(OUT_W-ACC_W){w_comb[CIC_N-1][ACC_W-1]}}, w_comb[CIC_N-1]};
      end
    end
  end

endmodule

// File: rtl/tsmc_digital_1_cic.sv
// Interleaved-ADC back-end: per-lane p-n minus DC offset, 4-lane sum or
// TEG test path as source, feeding the R=8 third-order CIC decimator.
module tsmc_digital_1_cic
  import tsmc_digital_1_pkg::*;
(
  input  logic             CLK,
  input  logic             RES_N,
  input  logic [IN_W-1:0]  IN_DFE_1_p,
  input  logic [IN_W-1:0]  IN_DFE_1_n,
  input  logic [IN_W-1:0]  IN_DFE_2_p,
  input  logic [IN_W-1:0]  IN_DFE_2_n,
  input  logic [IN_W-1:0]  IN_DFE_3_p,
  input  logic [IN_W-1:0]  IN_DFE_3_n,
  input  logic [IN_W-1:0]  IN_DFE_4_p,
  input  logic [IN_W-1:0]  IN_DFE_4_n,
  input  logic [IN_W-1:0]  IN_ADC_TEG_p,
  input  logic [IN_W-1:0]  IN_ADC_TEG_n,
  input  logic [OFF_W-1:0] dc_off_adc1,
  input  logic [OFF_W-1:0] dc_off_adc2,
  input  logic [OFF_W-1:0] dc_off_adc3,
  input  logic [OFF_W-1:0] dc_off_adc4,
  input  logic             ENABLE_DFE,
  input  logic             ENABLE_ADC_TEG,
  input  logic             ENABLE_DIVIDER_DFE,
  input  logic             ENABLE_DIVIDER_ADC_TEG,
  output logic             OUT_CLK,
  output logic [OUT_W-1:0] OUT
);

  logic [IN_W-1:0]   w_p    [4];
  logic [IN_W-1:0]   w_n    [4];
  logic [OFF_W-1:0]  w_off  [4];
  logic [DIFF_W-1:0] w_d    [4];
  logic [LANE_W-1:0] w_lane [4];
  logic [SUM_W-1:0]  w_dfe_sum;
  logic [DIFF_W-1:0] w_teg_d;
  logic [SUM_W-1:0]  w_sum;
  logic              w_en_div;
  src_e              w_src;

  assign w_p[0] = IN_DFE_1_p;  assign w_n[0] = IN_DFE_1_n;  assign w_off[0] = dc_off_adc1;
  assign w_p[1] = IN_DFE_2_p;  assign w_n[1] = IN_DFE_2_n;  assign w_off[1] = dc_off_adc2;
  assign w_p[2] = IN_DFE_3_p;  assign w_n[2] = IN_DFE_3_n;  assign w_off[2] = dc_off_adc3;
  assign w_p[3] = IN_DFE_4_p;  assign w_n[3] = IN_DFE_4_n;  assign w_off[3] = dc_off_adc4;

  always_comb begin
    w_dfe_sum = '0;
    for (int k = 0; k < 4; k++) begin
      w_d[k]    = code_diff(w_p[k], w_n[k]);
      w_lane[k] = {w_d[k][DIFF_W-1], w_d[k]} - {{(LANE_W-OFF_W){1'b0}}, w_off[k]};
      w_dfe_sum = w_dfe_sum + {{(SUM_W-LANE_W){w_lane[k][LANE_W-1]}}, w_lane[k]};
    end
  end

  assign w_teg_d = code_diff(IN_ADC_TEG_p, IN_ADC_TEG_n);

  // The TEG path stands in for all four lanes, hence the x4 scaling.
  always_comb begin
    w_src = ENABLE_ADC_TEG ? SRC_TEG : (ENABLE_DFE ? SRC_DFE : SRC_NONE);
    w_sum = '0;
    case (w_src)
      SRC_TEG: w_sum = {w_teg_d[DIFF_W-1], w_teg_d, 2'b00};
      SRC_DFE: w_sum = w_dfe_sum;
      default: w_sum = '0;
    endcase
    w_en_div = (w_src == SRC_TEG) ? ENABLE_DIVIDER_ADC_TEG : ENABLE_DIVIDER_DFE;
  end

  cic_decim u_cic_decim (
    .i_clk     (CLK),
    .i_rst_n   (RES_N),
    .i_sum     (w_sum),
    .i_en_div  (w_en_div),
    .o_out     (OUT),
    .o_out_clk (OUT_CLK)
  );

endmodule

// File: tb/tb_tsmc_digital_1_cic.sv
// Self-checking bench for tsmc_digital_1_cic: expected 512*S values are queued
// when the source is set up and compared at settled decimation ticks.
module tb_tsmc_digital_1_cic;

  logic        CLK = 1'b0;
  logic        RES_N = 1'b0;
  logic [5:0]  dfe_p [4];
  logic [5:0]  dfe_n [4];
  logic [2:0]  off   [4];
  logic [5:0]  teg_p, teg_n;
  logic        en_dfe, en_teg, div_dfe, div_teg;
  logic        OUT_CLK;
  logic [20:0] OUT;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 CLK = ~CLK;

  tsmc_digital_1_cic dut (
    .CLK                    (CLK),
    .RES_N                  (RES_N),
    .IN_DFE_1_p             (dfe_p[0]),
    .IN_DFE_1_n             (dfe_n[0]),
    .IN_DFE_2_p             (dfe_p[1]),
    .IN_DFE_2_n             (dfe_n[1]),
    .IN_DFE_3_p             (dfe_p[2]),
    .IN_DFE_3_n             (dfe_n[2]),
    .IN_DFE_4_p             (dfe_p[3]),
    .IN_DFE_4_n             (dfe_n[3]),
    .IN_ADC_TEG_p           (teg_p),
    .IN_ADC_TEG_n           (teg_n),
    .dc_off_adc1            (off[0]),
    .dc_off_adc2            (off[1]),
    .dc_off_adc3            (off[2]),
    .dc_off_adc4            (off[3]),
    .ENABLE_DFE             (en_dfe),
    .ENABLE_ADC_TEG         (en_teg),
    .ENABLE_DIVIDER_DFE     (div_dfe),
    .ENABLE_DIVIDER_ADC_TEG (div_teg),
    .OUT_CLK                (OUT_CLK),
    .OUT                    (OUT)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int src_sum();
    int s;
    s = 0;
    if (en_teg) s = 4 * (int'(teg_p) - int'(teg_n));
    else if (en_dfe)
      for (int k = 0; k < 4; k++) s += int'(dfe_p[k]) - int'(dfe_n[k]) - int'(off[k]);
    return s;
  endfunction

  function automatic logic signed [31:0] out_s();
    return 32'(signed'(OUT));
  endfunction

  task automatic wait_tick(input string tag);
    bit   seen;
    logic prev;
    seen = 0;
    for (int i = 0; i < 24 && !seen; i++) begin
      prev = OUT_CLK;
      @(posedge CLK); #1;
      if (!prev && OUT_CLK) seen = 1;
    end
    if (!seen) check_val({tag, "_tick_timeout"}, 0, 1);
  endtask

  task automatic set_lanes(input int p, input int n, input int o);
    for (int k = 0; k < 4; k++) begin
      dfe_p[k] = 6'(p);
      dfe_n[k] = 6'(n);
      off[k]   = 3'(o);
    end
  endtask

  task automatic randomize_lanes();
    for (int k = 0; k < 4; k++) begin
      dfe_p[k] = 6'($urandom_range(0, 63));
      dfe_n[k] = 6'($urandom_range(0, 63));
      off[k]   = 3'($urandom_range(0, 7));
    end
  endtask

  // Wait well past the transient, then compare two consecutive outputs.
  task automatic settle_and_check(input string tag);
    exp_q.push_back(512 * src_sum());
    repeat (5) wait_tick(tag);
    for (int i = 0; i < 2; i++) begin
      wait_tick(tag);
      check_val(tag, out_s(), exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    int   per, hi, frozen;
    logic prev;

    RES_N = 1'b0;
    randomize_lanes();
    teg_p   = 6'($urandom_range(0, 63));
    teg_n   = 6'($urandom_range(0, 63));
    en_dfe  = 1'b1;
    en_teg  = 1'($urandom_range(0, 1));
    div_dfe = 1'b1;
    div_teg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(posedge CLK);
      #1;
      check_val("rst_out", out_s(), 0);
      check_val("rst_clk", 32'(OUT_CLK), 0);
    end

    set_lanes(20, 10, 0);
    en_teg  = 1'b0;
    div_teg = 1'b0;
    @(negedge CLK);
    RES_N = 1'b1;
    @(posedge CLK); #1;

    wait_tick("period");
    wait_tick("period");
    per = 1;
    hi  = 1;
    for (int i = 0; i < 20; i++) begin
      prev = OUT_CLK;
      @(posedge CLK); #1;
      if (!prev && OUT_CLK) break;
      per++;
      if (OUT_CLK) hi++;
    end
    check_val("clk_period", per, 8);
    check_val("clk_high", hi, 4);

    settle_and_check("dfe_dc");

    set_lanes(0, 0, 2);
    settle_and_check("offset_all");

    set_lanes(0, 0, 0);
    off[2] = 3'd7;
    settle_and_check("offset_lane3");

    en_dfe = 1'b0;
    randomize_lanes();
    settle_and_check("no_source");

    en_dfe  = 1'b1;
    en_teg  = 1'b1;
    teg_p   = 6'd63;
    teg_n   = 6'd0;
    div_dfe = 1'b0;
    div_teg = 1'b1;
    settle_and_check("teg_priority");

    div_teg = 1'b0;
    div_dfe = 1'b1;
    @(posedge CLK); #1;
    frozen = out_s();
    teg_p  = 6'd0;
    teg_n  = 6'd63;
    hi     = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge CLK); #1;
      if (OUT_CLK !== 1'b0) hi++;
    end
    check_val("div_off_clk", hi, 0);
    check_val("div_off_hold", out_s(), frozen);

    exp_q.push_back(512 * src_sum());
    div_teg = 1'b1;
    wait_tick("reenable");
    repeat (4) wait_tick("reenable");
    check_val("reenable_t4", out_s(), exp_q[0]);
    wait_tick("reenable");
    check_val("reenable_t5", out_s(), exp_q[0]);
    void'(exp_q.pop_front());

    en_teg = 1'b0;
    set_lanes(0, 63, 7);
    settle_and_check("extreme_neg");

    @(posedge CLK); #3;
    RES_N = 1'b0;
    #1;
    check_val("async_rst_out", out_s(), 0);
    check_val("async_rst_clk", 32'(OUT_CLK), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
